bus_select_arbiter: RTL and testbench

Parametrised, registered successor to the combinational 32-to-5 bus-source encoder in the datapath. It takes NUM_SRC one-per-source "drive bus" requests from the control unit. It produces a registered binary select for the bus multiplexer, with either fixed lowest-index-first priority or round-robin priority. It also flags cycles where more than one source requests the bus, and counts those conflicts for debug.

---
 rtl/bus_select_arbiter.sv | 91 +++++++++
 tb/tb_bus_select_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bus_select_arbiter.sv
// Registered bus-source arbiter: one-hot "drive bus" requests in, binary mux select out,
// with fixed or round-robin priority and a saturating conflict counter for debug.
module bus_select_arbiter #(
  parameter int NUM_SRC = 24,
  parameter int SEL_W   = 5,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NUM_SRC-1:0] req,
  input  logic               rr_mode,
  input  logic               err_clr,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               conflict,
  output logic [CNT_W-1:0]   conflict_cnt
);

  logic [SEL_W-1:0]   rr_ptr;
  logic [NUM_SRC-1:0] hi_mask_p0;
  logic [NUM_SRC-1:0] hi_req_p0;
  logic [SEL_W-1:0]   grant_p0;
  logic               any_p0;
  logic               multi_p0;

  logic [SEL_W-1:0]   sel_p1;
  logic               vld_p1;
  logic               conf_p1;
  logic [CNT_W-1:0]   cnt_p1;

  function automatic logic [SEL_W-1:0] lowest_idx(input logic [NUM_SRC-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = SEL_W'(i);
    end
  endfunction

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] g);
    if (g == SEL_W'(NUM_SRC - 1)) wrap_inc = '0;
    else                          wrap_inc = g + SEL_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) sat_inc = c;
    else                    sat_inc = c + CNT_W'(1);
  endfunction

  // Stage p0: combinational grant. Round-robin searches bits at/above rr_ptr first,
  // then falls back to the whole vector, which is the wrap-around half of the search.
  always_comb begin
    hi_mask_p0 = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hi_mask_p0[i] = (SEL_W'(i) >= rr_ptr);
    end
  end

  assign hi_req_p0 = req & hi_mask_p0;
  assign any_p0    = |req;
  assign multi_p0  = |(req & (req - NUM_SRC'(1)));

  always_comb begin
    grant_p0 = lowest_idx(req);
    if (rr_mode && (|hi_req_p0)) grant_p0 = lowest_idx(hi_req_p0);
  end

  // Stage p1: registered outputs; sel holds its last grant while nobody requests.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sel_p1  <= '0;
      vld_p1  <= 1'b0;
      conf_p1 <= 1'b0;
      cnt_p1  <= '0;
      rr_ptr  <= '0;
    end else begin
      if (any_p0) begin
        sel_p1 <= grant_p0;
        rr_ptr <= wrap_inc(grant_p0);
      end
      vld_p1  <= any_p0;
      conf_p1 <= multi_p0;
      if (err_clr)       cnt_p1 <= '0;
      else if (multi_p0) cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign sel          = sel_p1;
  assign sel_valid    = vld_p1;
  assign conflict     = conf_p1;
  assign conflict_cnt = cnt_p1;

endmodule

// File: tb/tb_bus_select_arbiter.sv
// Bench for bus_select_arbiter: directed steps plus randomized traffic checked against
// a behavioural model; a second instance with a 2-bit counter exercises saturation.
module tb_bus_select_arbiter;

  localparam int N = 24;

  logic          clk;
  logic          clr;
  logic [N-1:0]  req;
  logic          rr_mode;
  logic          err_clr;
  logic [4:0]    sel, sel2;
  logic          vld, vld2;
  logic          conf, conf2;
  logic [7:0]    cnt8;
  logic [1:0]    cnt2;

  int checks = 0;
  int errors = 0;

  int m_sel, m_vld, m_conf, m_cnt8, m_cnt2, m_ptr;

  bus_select_arbiter #(.NUM_SRC(N), .SEL_W(5), .CNT_W(8)) dut (
    .clk(clk), .clr(clr), .req(req), .rr_mode(rr_mode), .err_clr(err_clr),
    .sel(sel), .sel_valid(vld), .conflict(conf), .conflict_cnt(cnt8)
  );

  bus_select_arbiter #(.NUM_SRC(N), .SEL_W(5), .CNT_W(2)) dut_c2 (
    .clk(clk), .clr(clr), .req(req), .rr_mode(rr_mode), .err_clr(err_clr),
    .sel(sel2), .sel_valid(vld2), .conflict(conf2), .conflict_cnt(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sel = 0; m_vld = 0; m_conf = 0; m_cnt8 = 0; m_cnt2 = 0; m_ptr = 0;
  endtask

  // Reference: count requests, pick the winner by walking the sources in priority order.
  task automatic model_update();
    int n, g;
    n = $countones(req);
    g = -1;
    if (n > 0) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = rr_mode ? (m_ptr + k) % N : k;
        if (g < 0 && req[idx]) g = idx;
      end
      m_sel = g;
      m_ptr = (g + 1) % N;
    end
    m_vld  = (n > 0);
    m_conf = (n >= 2);
    if (err_clr) begin
      m_cnt8 = 0; m_cnt2 = 0;
    end else if (n >= 2) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3)   m_cnt2++;
    end
  endtask

  task automatic check_all();
    chk("sel", 32'(sel), 32'(m_sel));
    chk("sel_valid", 32'(vld), 32'(m_vld));
    chk("conflict", 32'(conf), 32'(m_conf));
    chk("cnt8", 32'(cnt8), 32'(m_cnt8));
    chk("sel_c2", 32'(sel2), 32'(m_sel));
    chk("sel_valid_c2", 32'(vld2), 32'(m_vld));
    chk("conflict_c2", 32'(conf2), 32'(m_conf));
    chk("cnt2", 32'(cnt2), 32'(m_cnt2));
  endtask

  task automatic step(input logic [N-1:0] r, input logic m, input logic ec);
    req = r; rr_mode = m; err_clr = ec;
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic async_reset(input logic [N-1:0] r);
    req = r; rr_mode = 1'b0; err_clr = 1'b0;
    clr = 1'b1;
    #1;
    model_reset();
    chk("arst_sel", 32'(sel), 32'd0);
    chk("arst_vld", 32'(vld), 32'd0);
    chk("arst_conf", 32'(conf), 32'd0);
    chk("arst_cnt8", 32'(cnt8), 32'd0);
    chk("arst_cnt2", 32'(cnt2), 32'd0);
    #2;
    clr = 1'b0;
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  initial begin
    logic [N-1:0] r;
    clr = 1'b1; req = '0; rr_mode = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    clr = 1'b0;

    // One-hot sweep in fixed mode
    for (int i = 0; i < N; i++) begin
      step(N'(1) << i, 1'b0, 1'b0);
      chk("sweep_sel", 32'(sel), 32'(i));
      chk("sweep_conf", 32'(conf), 32'd0);
    end
    step('0, 1'b0, 1'b0);
    chk("idle_hold_sel", 32'(sel), 32'd23);
    chk("idle_vld", 32'(vld), 32'd0);

    // Fixed-priority conflict held for four cycles
    r = '0; r[3] = 1'b1; r[16] = 1'b1; r[20] = 1'b1;
    step(r, 1'b0, 1'b0);
    chk("fix_sel", 32'(sel), 32'd3);
    chk("fix_cnt1", 32'(cnt8), 32'd1);
    repeat (3) step(r, 1'b0, 1'b0);
    chk("fix_cnt4", 32'(cnt8), 32'd4);
    chk("fix_cnt2_sat", 32'(cnt2), 32'd3);
    chk("fix_sel_hold", 32'(sel), 32'd3);

    // Grant source 23 to bring the pointer back to 0, then rotate
    step(N'(1) << 23, 1'b0, 1'b0);
    r = '0; r[2] = 1'b1; r[7] = 1'b1; r[23] = 1'b1;
    step(r, 1'b1, 1'b0); chk("rr_0", 32'(sel), 32'd2);
    step(r, 1'b1, 1'b0); chk("rr_1", 32'(sel), 32'd7);
    step(r, 1'b1, 1'b0); chk("rr_2", 32'(sel), 32'd23);
    step(r, 1'b1, 1'b0); chk("rr_3", 32'(sel), 32'd2);
    step(r, 1'b1, 1'b0); chk("rr_4", 32'(sel), 32'd7);
    chk("rr_conf", 32'(conf), 32'd1);

    // Wrap from 23 back to 0, then a mode switch
    r = '0; r[0] = 1'b1; r[23] = 1'b1;
    step(r, 1'b1, 1'b0); chk("wrap_23", 32'(sel), 32'd23);
    step(r, 1'b1, 1'b0); chk("wrap_0", 32'(sel), 32'd0);
    r = '0; r[5] = 1'b1; r[9] = 1'b1;
    step(r, 1'b0, 1'b0); chk("mode_sw", 32'(sel), 32'd5);

    // Two-bit counter saturation and clear priority
    step('0, 1'b0, 1'b1);
    chk("clr_cnt2", 32'(cnt2), 32'd0);
    r = '0; r[1] = 1'b1; r[2] = 1'b1;
    step(r, 1'b0, 1'b0); chk("sat_1", 32'(cnt2), 32'd1);
    step(r, 1'b0, 1'b0); chk("sat_2", 32'(cnt2), 32'd2);
    for (int i = 0; i < 4; i++) begin
      step(r, 1'b0, 1'b0); chk("sat_3", 32'(cnt2), 32'd3);
    end
    step(r, 1'b0, 1'b1); chk("errclr_wins", 32'(cnt2), 32'd0);
    step(r, 1'b0, 1'b0); chk("after_clr", 32'(cnt2), 32'd1);

    // 8-bit counter saturation
    for (int i = 0; i < 260; i++) step(r, 1'b1, 1'b0);
    chk("sat_255", 32'(cnt8), 32'd255);

    // Asynchronous reset mid-run
    async_reset(24'h000010);
    chk("arst_rel_sel", 32'(sel), 32'd4);
    chk("arst_rel_vld", 32'(vld), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r = N'(1) << $urandom_range(0, N - 1);
        2: r = (N'(1) << $urandom_range(0, N - 1)) | (N'(1) << $urandom_range(0, N - 1));
        default: r = N'($urandom);
      endcase
      if ($urandom_range(0, 99) == 0) async_reset(r);
      else step(r, 1'(($urandom_range(0, 3) != 0) ? 1 : 0), 1'($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
